// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU issue stage: operation encoding, NZCV flag
// positions and the command record that travels through the FIFO.
package alu_seq_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_ORR = 2'b11
  } alu_op_t;

  // Bit positions inside a 4-bit {N,Z,C,V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    alu_op_t          op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             chain;
    logic             setflags;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. A push is ignored when full and a pop when empty;
// pointers wrap modulo DEPTH (power of two).
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           push_i,
  input  alu_cmd_t       wdata_i,
  input  logic           pop_i,
  output alu_cmd_t       rdata_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [AW:0]    count_o
);

  alu_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the combinational 2-bit-control ALU: queues
// commands, drives the ALU from the FIFO head and registers each result.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int unsigned WIDTH = ALU_W,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  input  logic             cmd_chain_i,
  input  logic             cmd_setflags_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [1:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic [3:0]       alu_flags_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic [3:0]       rsp_flags_o,
  output logic [3:0]       flags_q_o,
  output logic [CW-1:0]    fifo_count_o
);

  // Handshakes: a transfer happens on an edge where valid && ready; valid is
  // never withdrawn by this block once raised, and ready may depend on state only.
  alu_cmd_t        push_cmd;
  alu_cmd_t        head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            issue;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [WIDTH-1:0] last_result_q, last_result_d;

  assign push_cmd = '{op:       alu_op_t'(cmd_op_i),
                      a:        cmd_a_i,
                      b:        cmd_b_i,
                      chain:    cmd_chain_i,
                      setflags: cmd_setflags_i};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_valid_i),
    .wdata_i (push_cmd),
    .pop_i   (issue),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign cmd_ready_o = !fifo_full;

  // The slot can take a new result when empty or when it drains this cycle.
  assign issue = !fifo_empty && (!rsp_valid_q || rsp_ready_i);

  always_comb begin
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_ctrl_o = OP_ADD;
    if (!fifo_empty) begin
      alu_a_o    = head.chain ? last_result_q : head.a;
      alu_b_o    = head.b;
      alu_ctrl_o = head.op;
    end
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    sticky_d      = sticky_q;
    last_result_d = last_result_q;
    if (issue) begin
      rsp_valid_d   = 1'b1;
      rsp_result_d  = alu_result_i;
      rsp_flags_d   = alu_flags_i;
      last_result_d = alu_result_i;
      if (head.setflags) sticky_d = alu_flags_i;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      sticky_q      <= '0;
      last_result_q <= '0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      sticky_q      <= sticky_d;
      last_result_q <= last_result_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign flags_q_o    = sticky_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: queue-based reference model checked every
// cycle, directed literal cases, then randomized traffic with occasional resets.
module tb_alu_cmd_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [W-1:0]  cmd_a_i;
  logic [W-1:0]  cmd_b_i;
  logic          cmd_chain_i;
  logic          cmd_setflags_i;
  logic [W-1:0]  alu_a_o;
  logic [W-1:0]  alu_b_o;
  logic [1:0]    alu_ctrl_o;
  logic [W-1:0]  alu_result_i;
  logic [3:0]    alu_flags_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [W-1:0]  rsp_result_o;
  logic [3:0]    rsp_flags_o;
  logic [3:0]    flags_q_o;
  logic [2:0]    fifo_count_o;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .cmd_a_i        (cmd_a_i),
    .cmd_b_i        (cmd_b_i),
    .cmd_chain_i    (cmd_chain_i),
    .cmd_setflags_i (cmd_setflags_i),
    .alu_a_o        (alu_a_o),
    .alu_b_o        (alu_b_o),
    .alu_ctrl_o     (alu_ctrl_o),
    .alu_result_i   (alu_result_i),
    .alu_flags_i    (alu_flags_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_flags_o    (rsp_flags_o),
    .flags_q_o      (flags_q_o),
    .fifo_count_o   (fifo_count_o)
  );

  // ALU behaviour: returns {N,Z,C,V,result}; carry of SUB is a + ~b + 1.
  function automatic logic [35:0] alu_fn(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c;
    logic        v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  assign {alu_flags_i, alu_result_i} = alu_fn(alu_ctrl_o, alu_a_o, alu_b_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        chain;
    logic        sf;
  } cmd_t;

  cmd_t        pend_q[$];
  logic [W-1:0] exp_q[$];
  logic        m_slot_v;
  logic [31:0] m_slot_res;
  logic [3:0]  m_slot_flg;
  logic [3:0]  m_flags;
  logic [31:0] m_last;
  bit          model_ok = 1'b0;

  always @(posedge clk_i) begin : model_p
    bit          do_issue;
    bit          do_push;
    cmd_t        c;
    logic [31:0] opa;
    logic [35:0] rf;
    if (reset_i) begin
      pend_q.delete();
      exp_q.delete();
      m_slot_v = 1'b0; m_slot_res = '0; m_slot_flg = '0;
      m_flags = '0; m_last = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      do_issue = (pend_q.size() > 0) && (!m_slot_v || rsp_ready_i);
      do_push  = cmd_valid_i && (pend_q.size() < DEPTH);
      if (do_issue) begin
        c   = pend_q.pop_front();
        opa = c.chain ? m_last : c.a;
        rf  = alu_fn(c.op, opa, c.b);
        m_slot_v   = 1'b1;
        m_slot_res = rf[31:0];
        m_slot_flg = rf[35:32];
        m_last     = rf[31:0];
        if (c.sf) m_flags = rf[35:32];
        exp_q.push_back(rf[31:0]);
      end else if (m_slot_v && rsp_ready_i) begin
        m_slot_v = 1'b0;
      end
      if (do_push)
        pend_q.push_back('{cmd_op_i, cmd_a_i, cmd_b_i, cmd_chain_i, cmd_setflags_i});
    end
  end

  // ---------------- per-cycle compare / scoreboard ----------------
  always @(negedge clk_i) begin
    if (model_ok) begin
      check("cmd_ready", cmd_ready_o, pend_q.size() < DEPTH);
      check("fifo_count", fifo_count_o, pend_q.size());
      check("rsp_valid", rsp_valid_o, m_slot_v);
      check("flags_q", flags_q_o, m_flags);
      if (pend_q.size() > 0) begin
        check("alu_a", alu_a_o, pend_q[0].chain ? m_last : pend_q[0].a);
        check("alu_b", alu_b_o, pend_q[0].b);
        check("alu_ctrl", alu_ctrl_o, pend_q[0].op);
      end else begin
        check("alu_idle", {alu_ctrl_o, alu_a_o, alu_b_o}, '0);
      end
      if (m_slot_v) begin
        check("rsp_result", rsp_result_o, m_slot_res);
        check("rsp_flags", rsp_flags_o, m_slot_flg);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) check("sb_unexpected_rsp", 1, 0);
        else                   check("sb_order", rsp_result_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic chain, input logic sf);
    cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_chain_i = chain; cmd_setflags_i = sf;
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic chain, input logic sf,
                       input logic [31:0] exp_a, input logic [31:0] exp_res,
                       input logic [3:0] exp_flg, input logic [3:0] exp_sticky);
    set_cmd(op, a, b, chain, sf);
    cmd_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    check({name, "_alu_a"}, alu_a_o, exp_a);
    step();
    check({name, "_valid"}, rsp_valid_o, 1'b1);
    check({name, "_result"}, rsp_result_o, exp_res);
    check({name, "_flags"}, rsp_flags_o, exp_flg);
    check({name, "_sticky"}, flags_q_o, exp_sticky);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got[$];
    int          got_k[$];
    int          acc;
    bit          took;
    bit          drained;

    reset_i = 1'b1; rsp_ready_i = 1'b0; cmd_valid_i = 1'b1;
    set_cmd(2'b00, 32'h1, 32'h1, 1'b0, 1'b1);
    repeat (3) step();
    reset_i = 1'b0; cmd_valid_i = 1'b0;
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_count", fifo_count_o, 3'd0);
    check("rst_flags", flags_q_o, 4'h0);
    check("rst_alu_a", alu_a_o, 32'h0);
    check("rst_alu_ctrl", alu_ctrl_o, 2'b00);

    do_op("add",   2'b00, 32'h5,         32'h3,        1'b0, 1'b1, 32'h5,  32'h8,    4'h0, 4'h0);
    do_op("sub",   2'b01, 32'h5,         32'h5,        1'b0, 1'b1, 32'h5,  32'h0,    4'h6, 4'h6);
    do_op("and",   2'b10, 32'hFF,        32'h0F,       1'b0, 1'b0, 32'hFF, 32'hF,    4'h0, 4'h6);
    do_op("addc",  2'b00, 32'hFFFF_FFFF, 32'h1,        1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 4'h6, 4'h6);
    do_op("chain", 2'b11, 32'hDEAD_BEEF, 32'h0000_F0F0, 1'b1, 1'b0, 32'h0, 32'hF0F0, 4'h0, 4'h6);

    // Backpressure: slot blocked, FIFO fills, sixth command waits.
    step();
    rsp_ready_i = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      set_cmd(2'b00, acc + 1, acc + 1, 1'b0, 1'b0);
      cmd_valid_i = 1'b1;
      took = cmd_ready_o;
      step();
      if (took) acc++;
    end
    check("bp_accepted", acc, 5);
    check("bp_cmd_ready", cmd_ready_o, 1'b0);
    check("bp_count", fifo_count_o, 3'd4);
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 20 && got.size() < 6; k++) begin
      if (rsp_valid_o) begin
        got.push_back(rsp_result_o);
        got_k.push_back(k);
      end
      took = cmd_valid_i && cmd_ready_o;
      step();
      if (took) cmd_valid_i = 1'b0;
    end
    check("bp_rsp_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      check("bp_order", got[i], 2 * (i + 1));
    if (got_k.size() >= 5) check("bp_back_to_back", got_k[4] - got_k[0], 4);

    // Reset with queued work and a pending response.
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_cmd(2'b01, 32'h1, 32'h2, 1'b0, 1'b1);
      cmd_valid_i = 1'b1;
      step();
    end
    cmd_valid_i = 1'b0;
    check("mid_count", fifo_count_o, 3'd3);
    check("mid_rsp_valid", rsp_valid_o, 1'b1);
    check("mid_flags", flags_q_o, 4'h8);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("mid_rst_count", fifo_count_o, 3'd0);
    check("mid_rst_valid", rsp_valid_o, 1'b0);
    check("mid_rst_flags", flags_q_o, 4'h0);
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid_no_stale", rsp_valid_o, 1'b0);
    end

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      reset_i     = ($urandom_range(0, 99) == 0);
      cmd_valid_i = ($urandom_range(0, 9) < 7);
      rsp_ready_i = ($urandom_range(0, 9) < 6);
      set_cmd(2'($urandom_range(0, 3)), rand_val(), rand_val(),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      step();
    end

    reset_i = 1'b0; cmd_valid_i = 1'b0; rsp_ready_i = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 20 && !drained; k++) begin
      step();
      drained = (fifo_count_o == 3'd0) && !rsp_valid_o;
    end
    check("drain_done", drained, 1'b1);
    check("drain_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
